// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer: data/instruction waitrequest, mult/div occupancy, sticky HALT.
// Optional STALL_COUNTER_EN adds a saturating stall-cycle counter on stall_cycles.
module pipeline_stall_controller #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_req,
  input  logic        instr_waitrequest,
  input  logic        data_read_req,
  input  logic        data_write_req,
  input  logic        data_waitrequest,
  input  logic        muldiv_start_execute,
  input  logic        HALT_writeback,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        stall_memory,
  output logic        flush_decode_execute,
  output logic        flush_memory_writeback,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic        active,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             done_nxt;
  logic             dwait, iwait;

  assign dwait = (data_read_req | data_write_req) & data_waitrequest;
  assign iwait = instr_read_req & instr_waitrequest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= '0;
      pend        <= 1'b0;
      muldiv_done <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      muldiv_done <= done_nxt;
      active      <= (state_nxt != HALTED);
    end
  end

  always_comb begin
    state_nxt              = state;
    cnt_nxt                = cnt;
    pend_nxt               = pend;
    done_nxt               = 1'b0;
    stall_fetch            = 1'b0;
    stall_decode           = 1'b0;
    stall_execute          = 1'b0;
    stall_memory           = 1'b0;
    flush_decode_execute   = 1'b0;
    flush_memory_writeback = 1'b0;
    muldiv_busy            = 1'b0;
    case (state)
      RUN: begin
        stall_fetch = iwait | dwait;
        if (dwait) begin
          stall_decode           = 1'b1;
          stall_execute          = 1'b1;
          stall_memory           = 1'b1;
          flush_memory_writeback = 1'b1;
        end
        // A start seen under dwait is remembered so it is taken once the data bus frees.
        if (HALT_writeback) begin
          state_nxt = HALTED;
          pend_nxt  = 1'b0;
        end else if (dwait) begin
          pend_nxt = pend | muldiv_start_execute;
        end else if (muldiv_start_execute | pend) begin
          state_nxt = MULDIV;
          cnt_nxt   = CNT_LOAD;
          pend_nxt  = 1'b0;
        end
      end
      MULDIV: begin
        muldiv_busy   = 1'b1;
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_execute = 1'b1;
        if (dwait) begin
          stall_memory           = 1'b1;
          flush_memory_writeback = 1'b1;
        end
        cnt_nxt = (cnt != '0) ? cnt - 1'b1 : '0;
        if (HALT_writeback) begin
          state_nxt = HALTED;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end
      HALTED: begin
        stall_fetch            = 1'b1;
        stall_decode           = 1'b1;
        stall_execute          = 1'b1;
        stall_memory           = 1'b1;
        flush_memory_writeback = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      stall_fetch            = 1'b0;
      stall_decode           = 1'b0;
      stall_execute          = 1'b0;
      stall_memory           = 1'b0;
      flush_decode_execute   = 1'b0;
      flush_memory_writeback = 1'b0;
      muldiv_busy            = 1'b0;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_fetch && state != HALTED && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MULDIV_CYCLES=4).
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_read_req = 1'b0;
  logic        instr_waitrequest = 1'b0;
  logic        data_read_req = 1'b0;
  logic        data_write_req = 1'b0;
  logic        data_waitrequest = 1'b0;
  logic        muldiv_start_execute = 1'b0;
  logic        HALT_writeback = 1'b0;
  logic        stall_fetch, stall_decode, stall_execute, stall_memory;
  logic        flush_decode_execute, flush_memory_writeback;
  logic        muldiv_busy, muldiv_done, active;
  logic [31:0] stall_cycles;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Packed view: {sf, sd, se, sm, fde, fmw, busy, done, active}
  localparam logic [8:0] O_RESET  = 9'b000000000;
  localparam logic [8:0] O_IDLE   = 9'b000000001;
  localparam logic [8:0] O_DWAIT  = 9'b111101001;
  localparam logic [8:0] O_IWAIT  = 9'b100000001;
  localparam logic [8:0] O_BUSY   = 9'b111000101;
  localparam logic [8:0] O_BUSYDW = 9'b111101101;
  localparam logic [8:0] O_DONE   = 9'b000000011;
  localparam logic [8:0] O_HALTED = 9'b111101000;

`ifdef STALL_COUNTER_EN
  localparam logic [31:0] EXP_STALLS = 32'd5;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  pipeline_stall_controller #(.MULDIV_CYCLES(4), .CNT_W(5)) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .instr_read_req         (instr_read_req),
    .instr_waitrequest      (instr_waitrequest),
    .data_read_req          (data_read_req),
    .data_write_req         (data_write_req),
    .data_waitrequest       (data_waitrequest),
    .muldiv_start_execute   (muldiv_start_execute),
    .HALT_writeback         (HALT_writeback),
    .stall_fetch            (stall_fetch),
    .stall_decode           (stall_decode),
    .stall_execute          (stall_execute),
    .stall_memory           (stall_memory),
    .flush_decode_execute   (flush_decode_execute),
    .flush_memory_writeback (flush_memory_writeback),
    .muldiv_busy            (muldiv_busy),
    .muldiv_done            (muldiv_done),
    .active                 (active),
    .stall_cycles           (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {23'd0, stall_fetch, stall_decode, stall_execute, stall_memory,
            flush_decode_execute, flush_memory_writeback, muldiv_busy, muldiv_done, active};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, then sample outputs.
  task automatic cyc(input logic dreq, input logic dw, input logic ireq, input logic iw,
                     input logic start, input logic halt);
    @(negedge clk);
    data_read_req        = dreq;
    data_waitrequest     = dw;
    instr_read_req       = ireq;
    instr_waitrequest    = iw;
    muldiv_start_execute = start;
    HALT_writeback       = halt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    data_read_req = 0; data_waitrequest = 0; instr_read_req = 0;
    instr_waitrequest = 0; muldiv_start_execute = 0; HALT_writeback = 0;
    #1;
    check("reset_held_outs", outs(), {23'd0, O_RESET});
    check("reset_held_cnt", stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    check("reset_release", outs(), {23'd0, O_IDLE});
  endtask

  initial begin
    #2;
    check("reset_held_at_t0", outs(), {23'd0, O_RESET});
    do_reset();

    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      check("dwait_run", outs(), {23'd0, O_DWAIT});
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("dwait_end", outs(), {23'd0, O_IDLE});

    cyc(0, 0, 0, 0, 1, 0);
    check("md_start_cycle", outs(), {23'd0, O_IDLE});
    cyc(0, 0, 0, 0, 0, 0);
    check("md_busy1", outs(), {23'd0, O_BUSY});
    cyc(1, 1, 0, 0, 0, 0);
    check("md_busy2_dwait", outs(), {23'd0, O_BUSYDW});
    cyc(0, 0, 0, 0, 0, 0);
    check("md_busy3", outs(), {23'd0, O_BUSY});
    cyc(0, 0, 0, 0, 0, 0);
    check("md_busy4", outs(), {23'd0, O_BUSY});
    cyc(0, 0, 0, 0, 0, 0);
    check("md_done", outs(), {23'd0, O_DONE});
    cyc(0, 0, 0, 0, 0, 0);
    check("md_after_done", outs(), {23'd0, O_IDLE});

    cyc(1, 1, 0, 0, 1, 0);
    check("start_dwait1", outs(), {23'd0, O_DWAIT});
    cyc(1, 1, 0, 0, 0, 0);
    check("start_dwait2", outs(), {23'd0, O_DWAIT});
    cyc(0, 0, 0, 0, 0, 0);
    check("start_taken", outs(), {23'd0, O_IDLE});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("held_busy", outs(), {23'd0, O_BUSY});
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("b2b_done", outs(), {23'd0, O_DONE});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("b2b_busy", outs(), {23'd0, O_BUSY});
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("b2b_done2", outs(), {23'd0, O_DONE});

    cyc(0, 0, 1, 1, 0, 0);
    check("iwait", outs(), {23'd0, O_IWAIT});
    cyc(0, 0, 1, 0, 0, 0);
    check("iwait_end", outs(), {23'd0, O_IDLE});

    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("halt_in_md", outs(), {23'd0, O_BUSY});
    cyc(0, 0, 0, 0, 0, 0);
    check("halted1", outs(), {23'd0, O_HALTED});
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 1, 1, 0);
      check("halted_sticky", outs(), {23'd0, O_HALTED});
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
      check("cnt_iwait", outs(), {23'd0, O_IWAIT});
    end
    cyc(0, 0, 0, 0, 0, 1);
    check("cnt_halt_cycle", outs(), {23'd0, O_IDLE});
    cyc(0, 0, 1, 1, 0, 0);
    check("cnt_halted", outs(), {23'd0, O_HALTED});
    check("stall_cycles", stall_cycles, EXP_STALLS);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
    check("stall_cycles_frozen", stall_cycles, EXP_STALLS);

    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
